// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs between the sensor front-end and the monitor.
// Signal names match those the round-robin monitor consumes.
interface sensor_conditioner_if;
  logic       raw_fd;
  logic       raw_rd;
  logic       raw_w;
  logic       raw_fa;
  logic [6:0] raw_t;
  logic       raw_t_valid;
  logic       SFD;
  logic       SRD;
  logic       SW;
  logic       SFA;
  logic [6:0] ST;
  logic       st_primed;
  logic [3:0] chg;

  modport master (
    output raw_fd, raw_rd, raw_w, raw_fa, raw_t, raw_t_valid,
    input  SFD, SRD, SW, SFA, ST, st_primed, chg
  );

  modport slave (
    input  raw_fd, raw_rd, raw_w, raw_fa, raw_t, raw_t_valid,
    output SFD, SRD, SW, SFA, ST, st_primed, chg
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronises and debounces four contact sensors and produces a windowed moving
// average of the temperature reading, holding a safe value until the window fills.
module sensor_conditioner #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned ST_SAFE    = 60
) (
  input logic                 Clk,
  input logic                 Rst,
  sensor_conditioner_if.slave bus
);
  localparam int unsigned NCH   = 4;
  localparam int unsigned TW    = 7;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUMW  = TW + AVG_LOG2;
  localparam int unsigned PW    = AVG_LOG2;
  localparam int unsigned NW    = AVG_LOG2 + 1;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q, s2_q;
  logic [NCH-1:0] out_q, out_d;
  logic [NCH-1:0] chg_q, chg_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  logic [TW-1:0]   samp_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [NW-1:0]   n_q, n_d;
  logic            primed_q, primed_d;
  logic [TW-1:0]   st_q, st_d;

  assign raw = {bus.raw_fd, bus.raw_rd, bus.raw_w, bus.raw_fa};

  // Per-channel debounce: accept s2 after DEB_CYCLES consecutive mismatches.
  always_comb begin
    out_d = out_q;
    chg_d = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          out_d[i] = s2_q[i];
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Running sum swaps the oldest buffered sample for the new one.
  always_comb begin
    wp_d     = wp_q;
    sum_d    = sum_q;
    n_d      = n_q;
    primed_d = primed_q;
    st_d     = st_q;
    if (bus.raw_t_valid) begin
      wp_d  = wp_q + PW'(1);
      sum_d = sum_q + SUMW'(bus.raw_t) - SUMW'(samp_q[wp_q]);
      if (n_q != NW'(DEPTH)) begin
        n_d = n_q + NW'(1);
      end
      primed_d = (n_d == NW'(DEPTH));
      st_d     = primed_d ? TW'(sum_d >> AVG_LOG2) : TW'(ST_SAFE);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= '0;
      chg_q    <= '0;
      cnt_q    <= '{default: '0};
      samp_q   <= '{default: '0};
      wp_q     <= '0;
      sum_q    <= '0;
      n_q      <= '0;
      primed_q <= 1'b0;
      st_q     <= TW'(ST_SAFE);
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      out_q    <= out_d;
      chg_q    <= chg_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      sum_q    <= sum_d;
      n_q      <= n_d;
      primed_q <= primed_d;
      st_q     <= st_d;
      if (bus.raw_t_valid) begin
        samp_q[wp_q] <= bus.raw_t;
      end
    end
  end

  assign bus.SFD       = out_q[3];
  assign bus.SRD       = out_q[2];
  assign bus.SW        = out_q[1];
  assign bus.SFA       = out_q[0];
  assign bus.chg       = chg_q;
  assign bus.ST        = st_q;
  assign bus.st_primed = primed_q;

endmodule
